// File: rtl/seq_timing_decoder.sv
// -----------------------------------------------------------------------------
// seq_timing_decoder
//
// Control-unit front end for a basic computer.
//   - A SC_W-bit sequence counter (SC) is decoded into one-hot timing strobes
//     T0..T(2^SC_W-1).
//   - A latched 3-bit opcode is decoded into one-hot D0..D7.
//   - The indirect bit I is captured alongside the opcode.
// Downstream control gates combine Ti, Dj and I.
//
// Optional feature (macro SEQ_TIMING_DECODER_HALT_EN):
//   - Adds a start/stop flip-flop (r_run) driven by the start and hlt ports.
//   - While stopped, SC holds and t_out is 0. sc_clr still clears SC.
//   - With the macro undefined, the block behaves as permanently running.
//
// Ports:
//   clk      in   1         system clock, rising edge
//   rst_n    in   1         asynchronous active-low reset
//   sc_inr   in   1         increment SC on the next edge
//   sc_clr   in   1         clear SC on the next edge (overrides sc_inr)
//   ir_ld    in   1         capture ir_op / ir_i on the next edge
//   ir_op    in   3         opcode field IR[14:12]
//   ir_i     in   1         indirect bit IR[15]
//   dec_en   in   1         timing-decoder enable (0 forces t_out to 0)
//   start    in   1         set run flip-flop   (HALT_EN builds only)
//   hlt      in   1         clear run flip-flop (HALT_EN builds only)
//   sc_q     out  SC_W      current SC value
//   t_out    out  2^SC_W    one-hot timing strobes, bit k = Tk
//   d_out    out  8         registered one-hot opcode decode, bit j = Dj
//   i_flag   out  1         registered indirect bit
//   sc_wrap  out  1         one-cycle pulse after SC wraps all-ones -> 0
// -----------------------------------------------------------------------------
module seq_timing_decoder #(
  parameter  int SC_W = 4,
  localparam int T_W  = 1 << SC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sc_inr,
  input  logic            sc_clr,
  input  logic            ir_ld,
  input  logic [2:0]      ir_op,
  input  logic            ir_i,
  input  logic            dec_en,
`ifdef SEQ_TIMING_DECODER_HALT_EN
  input  logic            start,
  input  logic            hlt,
`endif
  output logic [SC_W-1:0] sc_q,
  output logic [T_W-1:0]  t_out,
  output logic [7:0]      d_out,
  output logic            i_flag,
  output logic            sc_wrap
);

  logic [SC_W-1:0] r_sc;
  logic            r_sc_wrap;
  logic [7:0]      r_d;
  logic            r_i;
  logic            w_run;
  logic            w_inc;
  logic            w_at_max;

`ifdef SEQ_TIMING_DECODER_HALT_EN
  logic r_run;

  // Stop has priority over start, so a simultaneous pulse leaves the machine stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else if (hlt) begin
      r_run <= 1'b0;
    end else if (start) begin
      r_run <= 1'b1;
    end
  end

  assign w_run = r_run;
`else
  assign w_run = 1'b1;
`endif

  assign w_at_max = (r_sc == {SC_W{1'b1}});
  // An increment counts only when running and not overridden by a clear.
  assign w_inc    = sc_inr && !sc_clr && w_run;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc      <= '0;
      r_sc_wrap <= 1'b0;
    end else begin
      if (sc_clr) begin
        r_sc <= '0;
      end else if (w_inc) begin
        r_sc <= r_sc + 1'b1;
      end
      // A clear at all-ones is not a wrap, so the pulse keys on w_inc only.
      r_sc_wrap <= w_inc && w_at_max;
    end
  end

  // Opcode path is independent of the SC path.
  // Reset lands on D0 so d_out is one-hot from the first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d <= 8'h01;
      r_i <= 1'b0;
    end else if (ir_ld) begin
      r_d <= 8'h01 << ir_op;
      r_i <= ir_i;
    end
  end

  // Timing decode is combinational so the strobe tracks sc_q and dec_en with no delay.
  assign t_out   = (dec_en && w_run) ? ({{(T_W-1){1'b0}}, 1'b1} << r_sc) : '0;
  assign sc_q    = r_sc;
  assign sc_wrap = r_sc_wrap;
  assign d_out   = r_d;
  assign i_flag  = r_i;

endmodule
